hazard_stall_unit: RTL

//  Pipeline hazard/stall controller for the 5-stage RV32 core; producer side of the operand bypass path.

---
 rtl/hazard_stall_if.sv | 40 ++++
 rtl/hazard_stall_unit.sv | 102 ++++++++++
 2 files changed

// File: rtl/hazard_stall_if.sv
// Bundle of ID/EX hazard inputs and pipeline control outputs between the core pipeline and hazard_stall_unit.
interface hazard_stall_if #(parameter int CNT_WIDTH = 32);
    logic [4:0]           rs1_id;
    logic [4:0]           rs2_id;
    logic                 rs1_used_id;
    logic                 rs2_used_id;
    logic [4:0]           rd_id;
    logic                 reg_wr_id;
    logic                 md_op_id;
    logic [4:0]           rd_ex;
    logic                 mem_read_ex;
    logic                 md_issue_ex;
    logic                 branch_mispredict;
    logic                 mem_stall;
    logic                 wb_busy;
    logic                 stall_if;
    logic                 stall_id;
    logic                 stall_ex;
    logic                 stall_mem;
    logic                 flush_id;
    logic                 bubble_ex;
    logic                 md_busy;
    logic                 md_wb_valid;
    logic [4:0]           md_wb_rd;
    logic [CNT_WIDTH-1:0] stall_cycles;

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_id, reg_wr_id, md_op_id,
               rd_ex, mem_read_ex, md_issue_ex, branch_mispredict, mem_stall, wb_busy,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex,
               md_busy, md_wb_valid, md_wb_rd, stall_cycles
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_id, reg_wr_id, md_op_id,
               rd_ex, mem_read_ex, md_issue_ex, branch_mispredict, mem_stall, wb_busy,
        output stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex,
               md_busy, md_wb_valid, md_wb_rd, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / multi-cycle-unit hazard detection, stall/flush generation and MD writeback tracking.
//  state | meaning
//  IDLE  | no MD op outstanding
//  BUSY  | MD op executing, cnt counts down remaining cycles
//  DONE  | result ready, strobing writeback whenever WB port is free
module hazard_stall_unit #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_WIDTH  = 32
) (
    input logic           clk,
    input logic           rst,
    hazard_stall_if.slave bus
);
    localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [4:0]     md_rd_q, md_rd_nxt;
    logic           ldu, mdh, md_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            md_rd_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            md_rd_q <= md_rd_nxt;
        end
    end

    // Issue is refused while memory stalls; EX will present it again.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        md_rd_nxt = md_rd_q;
        case (state)
            IDLE: begin
                if (bus.md_issue_ex && !bus.mem_stall) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CW'(MD_LATENCY - 1);
                    md_rd_nxt = bus.rd_ex;
                end
            end
            BUSY: begin
                if (cnt != '0) cnt_nxt = cnt - CW'(1);
                else           state_nxt = DONE;
            end
            DONE: begin
                if (!bus.wb_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ldu = bus.mem_read_ex && (bus.rd_ex != 5'd0) &&
              ((bus.rs1_used_id && (bus.rs1_id == bus.rd_ex)) ||
               (bus.rs2_used_id && (bus.rs2_id == bus.rd_ex)));
        md_hit = (md_rd_q != 5'd0) &&
                 ((bus.rs1_used_id && (bus.rs1_id == md_rd_q)) ||
                  (bus.rs2_used_id && (bus.rs2_id == md_rd_q)) ||
                  (bus.reg_wr_id   && (bus.rd_id  == md_rd_q)));
        mdh = (state != IDLE) && (bus.md_op_id || md_hit);

        bus.stall_if  = 1'b0;
        bus.stall_id  = 1'b0;
        bus.stall_ex  = 1'b0;
        bus.stall_mem = 1'b0;
        bus.flush_id  = 1'b0;
        bus.bubble_ex = 1'b0;
        if (bus.branch_mispredict) begin
            bus.flush_id  = 1'b1;
            bus.bubble_ex = 1'b1;
        end else if (bus.mem_stall) begin
            bus.stall_if  = 1'b1;
            bus.stall_id  = 1'b1;
            bus.stall_ex  = 1'b1;
            bus.stall_mem = 1'b1;
        end else if (ldu || mdh) begin
            bus.stall_if  = 1'b1;
            bus.stall_id  = 1'b1;
            bus.bubble_ex = 1'b1;
        end

        bus.md_busy     = (state != IDLE);
        bus.md_wb_valid = (state == DONE) && !bus.wb_busy;
        bus.md_wb_rd    = (state == DONE) ? md_rd_q : 5'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         bus.stall_cycles <= '0;
        else if (bus.stall_id && (bus.stall_cycles != '1)) bus.stall_cycles <= bus.stall_cycles + 1'b1;
    end
endmodule
